uart_rx: RTL and testbench

- Serial receiver; the downstream counterpart of uart_tx. Consumes the 8N1 line that uart_tx drives and produces parallel bytes.
- Resynchronises the asynchronous rx line, detects the start bit and majority-samples every bit at mid-period.
- Presents each byte on a valid/ready handshake to the core-side consumer (MMIO UART register block).
- Flags framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop resynchroniser, majority-of-three mid-bit sampling,
// valid/ready byte output with one-cycle framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          maj, dec, last, good, hs;

  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign dec  = (cnt_q == CNT_DEC);
  assign last = (cnt_q == CNT_LAST);
  assign hs   = valid_q & rx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good    = 1'b0;

    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_S0) samp_d[0] = rx_s_q;
      if (cnt_q == CNT_S1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (dec) shift_d[idx_q] = maj;
        if (last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (dec) begin
          cnt_d = '0;
          if (maj) begin
            good    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A handshake in the arrival cycle frees the slot, so the new byte replaces it.
    if (hs) valid_d = 1'b0;
    if (good) begin
      if (!valid_q || hs) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven in real time, a transaction-level model
// predicts the event each frame must produce and a negedge monitor checks every output.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C       = 32;
  localparam int HALF    = C / 2;
  localparam int BIT_NS  = C * 10;
  localparam int LAT_NOM = 2 + 9 * C + HALF + 1;
  localparam int K_BYTE  = 0;
  localparam int K_FERR  = 1;
  localparam int K_OVR   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned fall;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  held = 1'b0;
  bit  ready_tied = 1'b0;
  bit  hs_on_arrival = 1'b0;

  function automatic string kname(input int k);
    if (k == K_BYTE) return "byte";
    if (k == K_FERR) return "frame_err";
    return "overrun";
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic void got_event(input int kind, input logic [7:0] d);
    ev_t e;
    int  lat;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s data %h at cycle %0d, expected no event",
               kname(kind), d, cyc);
      return;
    end
    e   = exp_q.pop_front();
    lat = int'(cyc - e.fall) - 1;
    if (e.kind != kind || (kind == K_BYTE && e.data !== d) ||
        lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      n_fail++;
      $display("FAIL event: got %s data %h latency %0d, expected %s data %h latency %0d+-1",
               kname(kind), d, lat, kname(e.kind), e.data, LAT_NOM);
    end
  endfunction

  // Monitor: new-byte detection, error pulses and hold-stability, every cycle out of reset.
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
      prev_data  <= '0;
    end else begin
      if (rx_valid && (!prev_valid || prev_hs)) got_event(K_BYTE, rx_data);
      if (rx_frame_err) got_event(K_FERR, 8'h00);
      if (rx_overrun)   got_event(K_OVR, 8'h00);
      if (prev_valid && !prev_hs) begin
        n_tests++;
        if (!rx_valid || rx_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold: got valid %b data %h, expected valid 1 data %h",
                   rx_valid, rx_data, prev_data);
        end
      end
      prev_valid <= rx_valid;
      prev_hs    <= rx_valid && rx_ready;
      prev_data  <= rx_data;
    end
  end

  // Predict the outcome of one frame, then drive it on the line.
  task automatic send(input logic [7:0] b, input logic stopv, input int bit_ns);
    ev_t e;
    e.fall = cyc;
    e.data = b;
    if (!stopv) begin
      e.kind = K_FERR;
    end else if (held && !hs_on_arrival) begin
      e.kind = K_OVR;
    end else begin
      e.kind = K_BYTE;
      held   = !ready_tied;
    end
    exp_q.push_back(e);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stopv;
    #(bit_ns);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] partial;
    rst      = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
    check("reset_ovr", {31'd0, rx_overrun}, 32'd0);
    rst = 1'b1;
    repeat (10) @(posedge clk);

    // Single byte held until one handshake cycle.
    send(8'h6A, 1'b1, BIT_NS);
    drain(40);
    repeat (5) @(posedge clk);
    #1;
    check("t1_data", {24'd0, rx_data}, 32'h6A);
    check("t1_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    held     = 1'b0;
    @(negedge clk);
    check("t1_valid_cleared", {31'd0, rx_valid}, 32'd0);

    // Back-to-back frames with ready tied high.
    rx_ready   = 1'b1;
    ready_tied = 1'b1;
    send(8'h00, 1'b1, BIT_NS);
    send(8'hFF, 1'b1, BIT_NS);
    drain(40);

    // Short low glitch, then a fast (-3%) transmitter.
    rx = 1'b0;
    #80;
    rx = 1'b1;
    #(BIT_NS * 12);
    send(8'h55, 1'b1, BIT_NS * 97 / 100);
    drain(40);

    // Framing error followed by a long break, then a slow (+3%) transmitter.
    send(8'h3C, 1'b0, BIT_NS);
    #(BIT_NS * 20);
    rx = 1'b1;
    #(BIT_NS * 2);
    drain(40);
    send(8'hC3, 1'b1, BIT_NS * 103 / 100);
    drain(40);

    // Overrun, then a handshake landing exactly on the arrival edge.
    rx_ready   = 1'b0;
    ready_tied = 1'b0;
    repeat (5) @(posedge clk);
    send(8'h11, 1'b1, BIT_NS);
    drain(40);
    send(8'h22, 1'b1, BIT_NS);
    drain(40);
    check("t5_data_kept", {24'd0, rx_data}, 32'h11);
    @(posedge clk);
    #1;
    hs_on_arrival = 1'b1;
    fork
      send(8'h33, 1'b1, BIT_NS);
      begin
        repeat (LAT_NOM + 1) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    hs_on_arrival = 1'b0;
    drain(40);
    check("t5_data_new", {24'd0, rx_data}, 32'h33);
    check("t5_valid_held", {31'd0, rx_valid}, 32'd1);

    // Reset in the middle of data bit 4 while a byte is still held.
    partial = 8'h96;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      #(BIT_NS);
    end
    rx = partial[4];
    #(BIT_NS / 2);
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    check("mid_reset_data", {24'd0, rx_data}, 32'h00);
    check("mid_reset_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_reset_ferr", {31'd0, rx_frame_err}, 32'd0);
    check("mid_reset_ovr", {31'd0, rx_overrun}, 32'd0);
    held = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #(BIT_NS * 12);
    rx_ready   = 1'b1;
    ready_tied = 1'b1;
    send(8'hA5, 1'b1, BIT_NS);
    drain(40);
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
